mix_col_seq: RTL
================

MIX_COL_SEQ -- requirements
Module: mix_col_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 The ports SHALL be as follows:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data presents a state to process
- in_ready  output  1  block can accept a state
- in_data  input  128  AES state; column c = in_data[127-32c -: 32], row 0 in the MSB byte of each column
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  consumer accepts out_data
- out_data  output  128  MixColumns result, same byte layout as in_data
- busy  output  1  high in CALC or DONE
REQ-003 The block SHALL have no parameters; the width is fixed at 128 bits.

Function
REQ-004 The block SHALL compute forward AES MixColumns per column, with matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02} over GF(2^8).
REQ-005 GF multiplication SHALL work as follows:
- xtime(b) = (b<<1) XOR (b[7] ? 8'h1b : 0), truncated to 8 bits.
- x3 = xtime(b) XOR b.
- x1 = b.
- Products SHALL be summed by XOR.
REQ-006 The FSM SHALL have the states IDLE, CALC and DONE, with a 2-bit column counter col_cnt.
REQ-007 In IDLE, in_ready=1.
- An acceptance is in_valid && in_ready at an edge.
- On acceptance the block SHALL capture in_data into an internal state register, clear col_cnt and go to CALC.
REQ-008 In CALC, in_ready=0.
- At each edge the block SHALL compute column col_cnt from the captured register and write it to the matching 32-bit slice of the result register, then increment col_cnt.
- After col_cnt==3 is processed, the block SHALL go to DONE.
REQ-009 Latency: if acceptance is at edge k, columns SHALL be written at edges k+1..k+4, and out_valid SHALL be 1 from edge k+4.
REQ-010 In DONE, out_valid=1 and in_ready=0.
- out_data SHALL hold stable while out_ready=0, for any number of cycles.
- The output handshake is out_valid && out_ready at an edge. It SHALL clear out_valid and return to IDLE at that edge.
REQ-011 The minimum acceptance-to-acceptance period SHALL be 6 cycles. No new state is accepted before the current result is consumed.
REQ-012 in_data and in_valid changes during CALC/DONE SHALL have no effect.
REQ-013 out_data SHALL reflect the result register at all times. It retains the last result after the handshake until the next column write.
REQ-014 busy SHALL equal (state != IDLE).

Reset
REQ-015 Asserting rst at an edge SHALL force the following at that edge, regardless of state or other inputs:
- state=IDLE
- col_cnt=0
- state and result registers = 0
- out_valid=0, so out_data=0
- in_ready=1 from the following cycle
REQ-016 A reset during CALC or DONE SHALL discard the in-flight result. in_valid coincident with rst SHALL NOT be accepted.

Configuration
REQ-017 When macro MIX_COL_INV_EN is defined:
- The block SHALL add input port inv_mode (1 bit), sampled only at acceptance and held internally until the next acceptance.
- inv_mode=1 SHALL select the inverse matrix rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
- These products SHALL be built from xtime chains: x9=x8^x1, xb=x8^x2^x1, xd=x8^x4^x1, xe=x8^x4^x2.
- inv_mode=0 SHALL give forward MixColumns.
REQ-018 When MIX_COL_INV_EN is undefined, inv_mode SHALL NOT exist, only forward MixColumns SHALL be built, and timing SHALL be identical in both builds.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic: in_data=128'hdb135345f20a225c01010101c6c6c6c6, out_ready=1 -> out_data=128'h8e4da1bc9fdc589d01010101c6c6c6c6; out_valid rises exactly 4 edges after acceptance.
- FIPS-197 round 1: in_data=128'hd4bf5d30e0b452aeb84111f11e2798e5 -> out_data=128'h046681e5e0cb199a48f8d37a2806264c.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data and out_valid stable; in_ready=0 throughout; a new in_valid is ignored; release -> handshake, IDLE next cycle.
- Reset mid-CALC: assert rst after 2 column edges -> next cycle out_valid=0, out_data=0, in_ready=1; a following block computes correctly.
- Back-to-back: in_valid held high with two states, out_ready=1 -> accept edges exactly 6 cycles apart; both results correct.
- MIX_COL_INV_EN build: inv_mode=1, in_data=128'h046681e5e0cb199a48f8d37a2806264c -> out_data=128'hd4bf5d30e0b452aeb84111f11e2798e5; inv_mode=0 in the same build reproduces the basic scenario.

Source files
------------

// File: rtl/mix_col_seq.sv
// Sequential AES MixColumns: one 32-bit column per cycle, valid/ready on both sides.
// Optional inverse MixColumns (inv_mode port) is built when MIX_COL_INV_EN is defined.
module mix_col_seq (
  input  logic         clk,
  input  logic         rst,
`ifdef MIX_COL_INV_EN
  input  logic         inv_mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       r_fsm;
  logic [1:0]   r_col;
  logic [127:0] r_st;
  logic [127:0] r_res;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [6:0]   w_base;
  logic [31:0]  w_col;
  logic [31:0]  w_new;
  logic [7:0]   w_a   [4];
  logic [7:0]   w_x2  [4];
  logic [7:0]   w_fwd [4];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column c occupies bits [127-32c -: 32]; row 0 is the MSB byte.
  assign w_base = {r_col, 5'b0};
  assign w_col  = r_st[7'd127 - w_base -: 32];

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign w_a[i]   = w_col[31-8*i -: 8];
    assign w_x2[i]  = xt(w_a[i]);
    assign w_fwd[i] = w_x2[i] ^ (w_x2[(i+1)%4] ^ w_a[(i+1)%4])
                    ^ w_a[(i+2)%4] ^ w_a[(i+3)%4];
  end

`ifdef MIX_COL_INV_EN
  logic       r_inv;
  logic [7:0] w_x4  [4];
  logic [7:0] w_x8  [4];
  logic [7:0] w_m9  [4];
  logic [7:0] w_mb  [4];
  logic [7:0] w_md  [4];
  logic [7:0] w_me  [4];
  logic [7:0] w_inv [4];

  for (genvar i = 0; i < 4; i++) begin : g_inv
    assign w_x4[i]  = xt(w_x2[i]);
    assign w_x8[i]  = xt(w_x4[i]);
    assign w_m9[i]  = w_x8[i] ^ w_a[i];
    assign w_mb[i]  = w_x8[i] ^ w_x2[i] ^ w_a[i];
    assign w_md[i]  = w_x8[i] ^ w_x4[i] ^ w_a[i];
    assign w_me[i]  = w_x8[i] ^ w_x4[i] ^ w_x2[i];
    assign w_inv[i] = w_me[i] ^ w_mb[(i+1)%4] ^ w_md[(i+2)%4] ^ w_m9[(i+3)%4];
  end

  assign w_new = r_inv ? {w_inv[0], w_inv[1], w_inv[2], w_inv[3]}
                       : {w_fwd[0], w_fwd[1], w_fwd[2], w_fwd[3]};
`else
  assign w_new = {w_fwd[0], w_fwd[1], w_fwd[2], w_fwd[3]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_col       <= 2'd0;
      r_st        <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MIX_COL_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        IDLE: if (in_valid) begin
          r_st       <= in_data;
          r_col      <= 2'd0;
          r_fsm      <= CALC;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
`ifdef MIX_COL_INV_EN
          r_inv      <= inv_mode;
`endif
        end
        CALC: begin
          r_res[7'd127 - w_base -: 32] <= w_new;
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_fsm       <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_res;
  assign busy      = r_busy;

endmodule
